// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package mips_mem_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/datamem_arbiter_if.sv
// Requester and memory-side signal bundle for datamem_arbiter.
// slave = the arbiter; master = requesters plus the memory that feed it.
interface datamem_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = mips_mem_pkg::ADDR_W,
    parameter int DATA_W = mips_mem_pkg::DATA_W
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_readMem;
    logic              mem_writeMem;
    logic [ADDR_W-1:0] mem_R_addr;
    logic [ADDR_W-1:0] mem_W_addr;
    logic [DATA_W-1:0] mem_W_data;
    logic [DATA_W-1:0] mem_R_data;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_R_data,
        output ack, rdata, busy, mem_readMem, mem_writeMem,
               mem_R_addr, mem_W_addr, mem_W_data
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_R_data,
        input  ack, rdata, busy, mem_readMem, mem_writeMem,
               mem_R_addr, mem_W_addr, mem_W_data
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-port winner select; round-robin pointer only moves when both ports tie.
module rr_arbiter2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       win_id
);
    logic rr_ptr_reg;

    always_comb begin
        win_id = 1'b0;
        case (req)
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr_reg;
            default: win_id = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else if (advance && (req == 2'b11) && (FIXED_PRIO == 0)) begin
            rr_ptr_reg <= ~win_id;
        end
    end
endmodule

// File: rtl/datamem_arbiter.sv
// Serialises two requesters onto a single-port data memory:
// IDLE latches the winner, ACC performs the access, RESP returns ack/rdata.
module datamem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = mips_mem_pkg::ADDR_W,
    parameter int DATA_W     = mips_mem_pkg::DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input logic               clk,
    input logic               rst,
    datamem_arbiter_if.slave  bus
);
    arb_state_t        state_reg, state_next;
    mem_req_t          req_reg;
    logic              win_reg;
    logic              win_id;
    logic [DATA_W-1:0] rdata_reg;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    assign win_addr  = win_id ? bus.addr1  : bus.addr0;
    assign win_wdata = win_id ? bus.wdata1 : bus.wdata0;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req),
        .advance (state_reg == IDLE),
        .win_id  (win_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|bus.req) state_next = ACC;
            ACC:     state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Requester inputs are only looked at in IDLE; later changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_reg   <= '0;
            win_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if ((state_reg == IDLE) && (|bus.req)) begin
                req_reg <= '{we: bus.we[win_id], addr: win_addr, wdata: win_wdata};
                win_reg <= win_id;
            end
            if ((state_reg == ACC) && !req_reg.we) begin
                rdata_reg <= bus.mem_R_data;
            end
        end
    end

    always_comb begin
        bus.busy         = (state_reg != IDLE);
        bus.rdata        = rdata_reg;
        bus.mem_readMem  = 1'b0;
        bus.mem_writeMem = 1'b0;
        bus.mem_R_addr   = '0;
        bus.mem_W_addr   = '0;
        bus.mem_W_data   = '0;
        if (state_reg == ACC) begin
            // A reset landing on the access cycle must not corrupt memory.
            bus.mem_writeMem = req_reg.we & ~rst;
            bus.mem_readMem  = ~req_reg.we;
            bus.mem_R_addr   = req_reg.addr;
            bus.mem_W_addr   = req_reg.addr;
            bus.mem_W_data   = req_reg.wdata;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign bus.ack[gi] = (state_reg == RESP) && (win_reg == 1'(gi));
    end
endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed plus randomized checks of datamem_arbiter against a transaction-level model.
module tb_datamem_arbiter;
    logic clk;
    logic rst;
    logic mem_clr;
    int   checks = 0;
    int   errors = 0;

    datamem_arbiter_if if_rr ();
    datamem_arbiter_if if_fp ();

    datamem_arbiter #(.FIXED_PRIO(0)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr));
    datamem_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .rst(rst), .bus(if_fp));

    // Behavioural single-port memories with combinational, tri-stated read.
    logic [31:0] mem_rr [1024];
    logic [31:0] mem_fp [1024];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem_rr[i] <= '0;
        end else if (if_rr.mem_writeMem) begin
            mem_rr[if_rr.mem_W_addr] <= if_rr.mem_W_data;
        end
    end
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem_fp[i] <= '0;
        end else if (if_fp.mem_writeMem) begin
            mem_fp[if_fp.mem_W_addr] <= if_fp.mem_W_data;
        end
    end
    assign if_rr.mem_R_data = if_rr.mem_readMem ? mem_rr[if_rr.mem_R_addr] : 'z;
    assign if_fp.mem_R_data = if_fp.mem_readMem ? mem_fp[if_fp.mem_R_addr] : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory contents and the round-robin turn.
    logic [31:0] ref_mem [1024];
    logic        model_ptr;
    logic        op_we   [2];
    logic [9:0]  op_addr [2];
    logic [31:0] op_data [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve every pending port on the round-robin DUT, in model order.
    task automatic run_round(input logic [1:0] pend);
        int order[$];
        if (pend == 2'b11) begin
            order.push_back(model_ptr ? 1 : 0);
            order.push_back(model_ptr ? 0 : 1);
            model_ptr = ~model_ptr;
        end else begin
            order.push_back(pend[1] ? 1 : 0);
        end
        if_rr.we     = {op_we[1], op_we[0]};
        if_rr.addr0  = op_addr[0];
        if_rr.addr1  = op_addr[1];
        if_rr.wdata0 = op_data[0];
        if_rr.wdata1 = op_data[1];
        if_rr.req    = pend;
        foreach (order[k]) begin
            int p = order[k];
            tick();
            check("acc_readMem", 32'(if_rr.mem_readMem), 32'(!op_we[p]));
            check("acc_writeMem", 32'(if_rr.mem_writeMem), 32'(op_we[p]));
            if (op_we[p]) begin
                check("acc_W_addr", 32'(if_rr.mem_W_addr), 32'(op_addr[p]));
                check("acc_W_data", if_rr.mem_W_data, op_data[p]);
            end else begin
                check("acc_R_addr", 32'(if_rr.mem_R_addr), 32'(op_addr[p]));
            end
            tick();
            check($sformatf("ack_port%0d", p), 32'(if_rr.ack), 32'(2'b01 << p));
            if (op_we[p]) ref_mem[op_addr[p]] = op_data[p];
            else check($sformatf("rdata_%03h", op_addr[p]), if_rr.rdata, ref_mem[op_addr[p]]);
            if_rr.req[p] = 1'b0;
            tick();
            check("idle_busy", 32'(if_rr.busy), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] pend;
        rst = 1'b1;
        mem_clr = 1'b1;
        model_ptr = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        if_rr.req = '0; if_rr.we = '0; if_rr.addr0 = '0; if_rr.addr1 = '0;
        if_rr.wdata0 = '0; if_rr.wdata1 = '0;
        if_fp.req = '0; if_fp.we = '0; if_fp.addr0 = '0; if_fp.addr1 = '0;
        if_fp.wdata0 = '0; if_fp.wdata1 = '0;
        tick();
        tick();
        mem_clr = 1'b0;
        check("rst_busy", 32'(if_rr.busy), 32'd0);
        check("rst_ack", 32'(if_rr.ack), 32'd0);
        check("rst_rdata", if_rr.rdata, 32'd0);
        check("rst_readMem", 32'(if_rr.mem_readMem), 32'd0);
        rst = 1'b0;
        tick();

        // Port 0 store then load of the same word.
        if_rr.req = 2'b01; if_rr.we = 2'b01; if_rr.addr0 = 10'h005; if_rr.wdata0 = 32'hDEADBEEF;
        tick();
        check("st_writeMem_acc", 32'(if_rr.mem_writeMem), 32'd1);
        check("st_busy", 32'(if_rr.busy), 32'd1);
        check("st_ack_early", 32'(if_rr.ack), 32'd0);
        tick();
        check("st_writeMem_resp", 32'(if_rr.mem_writeMem), 32'd0);
        check("st_ack", 32'(if_rr.ack), 32'b01);
        ref_mem[10'h005] = 32'hDEADBEEF;
        if_rr.req = 2'b00;
        tick();
        check("st_writeMem_idle", 32'(if_rr.mem_writeMem), 32'd0);
        op_we[0] = 1'b0; op_addr[0] = 10'h005; op_data[0] = '0;
        run_round(2'b01);

        // Tie with pointer at 0, then the following tie must go to port 1.
        op_we[0] = 1'b0; op_addr[0] = 10'h010; op_data[0] = '0;
        op_we[1] = 1'b1; op_addr[1] = 10'h011; op_data[1] = 32'h55AA55AA;
        run_round(2'b11);
        op_we[0] = 1'b0; op_addr[0] = 10'h011;
        op_we[1] = 1'b0; op_addr[1] = 10'h005;
        run_round(2'b11);

        // Fixed priority: port 0 re-requests every round and always wins.
        if_fp.req = 2'b11; if_fp.we = 2'b00; if_fp.addr0 = 10'h007; if_fp.addr1 = 10'h008;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("fp_ack_c%0d", k), 32'(if_fp.ack), (k % 3 == 2) ? 32'b01 : 32'b00);
            check($sformatf("fp_readMem_c%0d", k), 32'(if_fp.mem_readMem), (k % 3 == 1) ? 32'd1 : 32'd0);
        end
        if_fp.req = 2'b00;
        tick();

        // Reset landing on the ACC cycle of a store aborts it.
        op_we[1] = 1'b1; op_addr[1] = 10'h020; op_data[1] = 32'hCAFEF00D;
        run_round(2'b10);
        if_rr.req = 2'b10; if_rr.we = 2'b10; if_rr.addr1 = 10'h020; if_rr.wdata1 = 32'h12345678;
        tick();
        rst = 1'b1;
        if_rr.req = 2'b00;
        #1;
        check("rst_acc_writeMem", 32'(if_rr.mem_writeMem), 32'd0);
        tick();
        check("rst_acc_ack", 32'(if_rr.ack), 32'd0);
        check("rst_acc_busy", 32'(if_rr.busy), 32'd0);
        check("rst_acc_rdata", if_rr.rdata, 32'd0);
        rst = 1'b0;
        model_ptr = 1'b0;
        tick();
        check("rst_after_ack", 32'(if_rr.ack), 32'd0);
        op_we[0] = 1'b0; op_addr[0] = 10'h020;
        run_round(2'b01);

        // One-cycle pulse from port 1 during port 0's ACC is never served.
        if_rr.req = 2'b01; if_rr.we = 2'b10; if_rr.addr0 = 10'h005; if_rr.addr1 = 10'h030;
        tick();
        if_rr.req = 2'b11;
        tick();
        if_rr.req = 2'b00;
        check("pulse_ack0", 32'(if_rr.ack), 32'b01);
        check("pulse_rdata", if_rr.rdata, ref_mem[10'h005]);
        tick();
        check("pulse_busy1", 32'(if_rr.busy), 32'd0);
        tick();
        check("pulse_busy2", 32'(if_rr.busy), 32'd0);
        check("pulse_no_ack", 32'(if_rr.ack), 32'd0);
        check("pulse_no_write", 32'(if_rr.mem_writeMem), 32'd0);

        // Back-to-back port 0 loads of words 0..3 with req held throughout.
        for (int i = 0; i < 4; i++) begin
            op_we[0] = 1'b1; op_addr[0] = 10'(i); op_data[0] = $urandom;
            run_round(2'b01);
        end
        if_rr.we = 2'b00; if_rr.addr0 = 10'h000; if_rr.req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b2b_readMem_acc%0d", i), 32'(if_rr.mem_readMem), 32'd1);
            check($sformatf("b2b_R_addr%0d", i), 32'(if_rr.mem_R_addr), 32'(i));
            tick();
            check($sformatf("b2b_ack%0d", i), 32'(if_rr.ack), 32'b01);
            check($sformatf("b2b_rdata%0d", i), if_rr.rdata, ref_mem[i]);
            check($sformatf("b2b_readMem_resp%0d", i), 32'(if_rr.mem_readMem), 32'd0);
            if_rr.addr0 = 10'(i + 1);
            if (i == 3) if_rr.req = 2'b00;
            tick();
            check($sformatf("b2b_readMem_idle%0d", i), 32'(if_rr.mem_readMem), 32'd0);
        end

        // Randomized rounds against the model.
        for (int r = 0; r < 24; r++) begin
            pend = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                op_we[p]   = 1'($urandom_range(0, 1));
                op_addr[p] = 10'($urandom_range(0, 15));
                op_data[p] = $urandom;
            end
            run_round(pend);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
